// File: rtl/cpu_pkg.sv
// Shared opcode, funct, FSM state and datapath-control encodings for the
// multi-cycle instruction controller and its decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic ALUSRC_IMM = 1'b0;
    localparam logic ALUSRC_REG = 1'b1;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_JUMP = 2'd1;
    localparam logic [1:0] PC_REGA = 2'd2;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] RIN_ALU = 2'd0;
    localparam logic [1:0] RIN_MEM = 2'd1;
    localparam logic [1:0] RIN_PC4 = 2'd2;

    // Which states an instruction visits after DECODE.
    typedef enum logic [2:0] {
        PATH_ALU,
        PATH_LW,
        PATH_SW,
        PATH_BRANCH,
        PATH_JAL
    } path_t;

    typedef struct packed {
        logic [1:0] pc_next;
        logic       alu_src;
        logic [1:0] alu_ctrl;
        logic [1:0] reg_dst;
        logic [1:0] reg_in;
        logic       beq;
        logic       bne;
        path_t      path;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        pc_next:  PC_SEQ,
        alu_src:  ALUSRC_IMM,
        alu_ctrl: ALU_ADD,
        reg_dst:  DST_RT,
        reg_in:   RIN_ALU,
        beq:      1'b0,
        bne:      1'b0,
        path:     PATH_ALU
    };

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into a control bundle;
// anything not recognised yields the NOP bundle with illegal set.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir_bits;

    assign opcode         = ir[31:26];
    assign funct          = ir[5:0];
    assign unused_ir_bits = ^ir[25:6];

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        ctrl.alu_src  = ALUSRC_REG;
                        ctrl.reg_dst  = DST_RD;
                    end
                    FN_SUB: begin
                        ctrl.alu_src  = ALUSRC_REG;
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.reg_dst  = DST_RD;
                    end
                    FN_SLT: begin
                        ctrl.alu_src  = ALUSRC_REG;
                        ctrl.alu_ctrl = ALU_SLT;
                        ctrl.reg_dst  = DST_RD;
                    end
                    FN_JR: begin
                        ctrl.pc_next  = PC_REGA;
                        ctrl.path     = PATH_BRANCH;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.reg_in = RIN_MEM;
                ctrl.path   = PATH_LW;
            end
            OP_SW: ctrl.path = PATH_SW;
            OP_BEQ, OP_BNE: begin
                // Branch compare is a subtract of two registers.
                ctrl.alu_src  = ALUSRC_REG;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.beq      = (opcode == OP_BEQ);
                ctrl.bne      = (opcode == OP_BNE);
                ctrl.path     = PATH_BRANCH;
            end
            OP_J: begin
                ctrl.pc_next = PC_JUMP;
                ctrl.path    = PATH_BRANCH;
            end
            OP_JAL: begin
                ctrl.pc_next = PC_JUMP;
                ctrl.reg_dst = DST_R31;
                ctrl.reg_in  = RIN_PC4;
                ctrl.path    = PATH_JAL;
            end
            OP_ADDI: ctrl.alu_ctrl = ALU_ADD;
            OP_XORI: ctrl.alu_ctrl = ALU_XOR;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_ctrl.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencer,
// instruction register, registered datapath controls and retire counter.
module instr_ctrl
    import cpu_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                instr_req,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                mem_req,
    input  logic                mem_ready,
    output logic [1:0]          pc_next,
    output logic                alu_src,
    output logic [1:0]          alu_ctrl,
    output logic                beq,
    output logic                bne,
    output logic [1:0]          reg_dst,
    output logic [1:0]          reg_in,
    output logic                reg_we,
    output logic                mem_we,
    output logic                pc_we,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm,
    output logic [25:0]         addr,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                instr_req_q, instr_req_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire_now;

    ctrl_t dec_ctrl;
    logic  dec_illegal;

    instr_decode u_decode (
        .ir      (ir_q),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ctrl_d     = ctrl_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        illegal    = 1'b0;
        retire_now = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Fetch is only accepted once the request is actually out.
                if (instr_req_q && instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl_d = dec_ctrl;
                if (dec_illegal) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                beq = ctrl_q.beq;
                bne = ctrl_q.bne;
                case (ctrl_q.path)
                    PATH_BRANCH: begin
                        pc_we      = 1'b1;
                        retire_now = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    PATH_LW, PATH_SW: state_d = ST_MEM;
                    default:          state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (ctrl_q.path == PATH_SW);
                if (mem_ready) begin
                    if (ctrl_q.path == PATH_SW) begin
                        pc_we      = 1'b1;
                        retire_now = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                retire_now = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        instr_req_d = (state_d == ST_FETCH);
        retired_d   = retire_now ? retired_q + RETIRE_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            ctrl_q      <= CTRL_NOP;
            instr_req_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ctrl_q      <= ctrl_d;
            instr_req_q <= instr_req_d;
            retired_q   <= retired_d;
        end
    end

    assign instr_req = instr_req_q;
    assign retired   = retired_q;

    assign pc_next  = ctrl_q.pc_next;
    assign alu_src  = ctrl_q.alu_src;
    assign alu_ctrl = ctrl_q.alu_ctrl;
    assign reg_dst  = ctrl_q.reg_dst;
    assign reg_in   = ctrl_q.reg_in;

    assign rs   = ir_q[25:21];
    assign rt   = ir_q[20:16];
    assign rd   = ir_q[15:11];
    assign imm  = ir_q[15:0];
    assign addr = ir_q[25:0];

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed bench for instr_ctrl: per-cycle expectations are queued for each
// instruction and compared as the controller steps through its states.
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    always #5 clk = ~clk;

    logic        instr_req, mem_req, alu_src, beq, bne, reg_we, mem_we, pc_we, illegal;
    logic [1:0]  pc_next, alu_ctrl, reg_dst, reg_in;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [15:0] retired;

    // Narrow-counter copy driven by the same stimulus, used for wrap checks.
    logic        unused_w_ireq, unused_w_mreq, unused_w_src, unused_w_beq, unused_w_bne;
    logic        unused_w_rwe, unused_w_mwe, unused_w_pcwe, unused_w_ill;
    logic [1:0]  unused_w_pcn, unused_w_alu, unused_w_dst, unused_w_rin;
    logic [4:0]  unused_w_rs, unused_w_rt, unused_w_rd;
    logic [15:0] unused_w_imm;
    logic [25:0] unused_w_addr;
    logic [3:0]  retired_w;

    instr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_valid(instr_valid),
        .instr(instr), .mem_req(mem_req), .mem_ready(mem_ready), .pc_next(pc_next),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .beq(beq), .bne(bne), .reg_dst(reg_dst),
        .reg_in(reg_in), .reg_we(reg_we), .mem_we(mem_we), .pc_we(pc_we), .rs(rs),
        .rt(rt), .rd(rd), .imm(imm), .addr(addr), .illegal(illegal), .retired(retired)
    );

    instr_ctrl #(.RETIRE_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .instr_req(unused_w_ireq), .instr_valid(instr_valid),
        .instr(instr), .mem_req(unused_w_mreq), .mem_ready(mem_ready), .pc_next(unused_w_pcn),
        .alu_src(unused_w_src), .alu_ctrl(unused_w_alu), .beq(unused_w_beq), .bne(unused_w_bne),
        .reg_dst(unused_w_dst), .reg_in(unused_w_rin), .reg_we(unused_w_rwe),
        .mem_we(unused_w_mwe), .pc_we(unused_w_pcwe), .rs(unused_w_rs), .rt(unused_w_rt),
        .rd(unused_w_rd), .imm(unused_w_imm), .addr(unused_w_addr), .illegal(unused_w_ill),
        .retired(retired_w)
    );

    localparam logic [31:0] JUNK = 32'hFC00_0000;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_JAL = 4, K_ILL = 5;
    localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3, PH_W = 3'd4;

    typedef struct packed {
        logic       iv;
        logic       mr;
        logic [7:0] vec;   // {instr_req, mem_req, mem_we, reg_we, pc_we, beq, bne, illegal}
        logic       chk;   // datapath controls and IR fields must be valid this cycle
        logic [2:0] ph;
    } step_t;

    step_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_ret = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string ph_name(input logic [2:0] ph);
        case (ph)
            PH_F:    return "FETCH";
            PH_D:    return "DECODE";
            PH_E:    return "EXEC";
            PH_M:    return "MEM";
            default: return "WB";
        endcase
    endfunction

    function automatic step_t mk(input logic iv, input logic mr, input logic [7:0] vec,
                                 input logic chk, input logic [2:0] ph);
        step_t s;
        s.iv = iv; s.mr = mr; s.vec = vec; s.chk = chk; s.ph = ph;
        return s;
    endfunction

    // Expected controls {pc_next, alu_src, alu_ctrl, reg_dst, reg_in} from the encoding table.
    task automatic ref_decode(input logic [31:0] w, output int kind, output logic [8:0] ctl,
                              output logic eb, output logic en);
        kind = K_ALU; ctl = 9'h0; eb = 1'b0; en = 1'b0;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20:   ctl = {2'd0, 1'b1, 2'd0, 2'd1, 2'd0};
                6'h22:   ctl = {2'd0, 1'b1, 2'd1, 2'd1, 2'd0};
                6'h2A:   ctl = {2'd0, 1'b1, 2'd3, 2'd1, 2'd0};
                6'h08:   begin ctl = {2'd2, 1'b0, 2'd0, 2'd0, 2'd0}; kind = K_BR; end
                default: kind = K_ILL;
            endcase
            6'h23: begin ctl = {2'd0, 1'b0, 2'd0, 2'd0, 2'd1}; kind = K_LW; end
            6'h2B: kind = K_SW;
            6'h04: begin ctl = {2'd0, 1'b1, 2'd1, 2'd0, 2'd0}; kind = K_BR; eb = 1'b1; end
            6'h05: begin ctl = {2'd0, 1'b1, 2'd1, 2'd0, 2'd0}; kind = K_BR; en = 1'b1; end
            6'h02: begin ctl = {2'd1, 1'b0, 2'd0, 2'd0, 2'd0}; kind = K_BR; end
            6'h03: begin ctl = {2'd1, 1'b0, 2'd0, 2'd2, 2'd2}; kind = K_JAL; end
            6'h08: ctl = 9'h0;
            6'h0E: ctl = {2'd0, 1'b0, 2'd2, 2'd0, 2'd0};
            default: kind = K_ILL;
        endcase
    endtask

    // Runs one instruction; abort_at >= 0 pulls reset low in that step instead.
    task automatic run(input string name, input logic [31:0] w, input int fwait,
                       input int mwait, input int abort_at);
        int         kind;
        int         idx;
        logic [8:0] ctl;
        logic       eb, en, sw;
        step_t      s;
        string      tag;
        ref_decode(w, kind, ctl, eb, en);
        sw = (kind == K_SW);
        for (int i = 0; i < fwait; i++) sb_q.push_back(mk(1'b0, 1'b0, 8'b1000_0000, 1'b0, PH_F));
        sb_q.push_back(mk(1'b1, 1'b0, 8'b1000_0000, 1'b0, PH_F));
        if (kind == K_ILL) begin
            sb_q.push_back(mk(1'b1, 1'b1, 8'b0000_1001, 1'b0, PH_D));
        end else begin
            sb_q.push_back(mk(1'b1, 1'b1, 8'b0000_0000, 1'b0, PH_D));
            sb_q.push_back(mk(1'b1, 1'b1, {4'b0000, kind == K_BR, eb, en, 1'b0}, 1'b1, PH_E));
            if (kind == K_LW || kind == K_SW) begin
                for (int i = 0; i < mwait; i++)
                    sb_q.push_back(mk(1'b1, 1'b0, {2'b01, sw, 5'b00000}, 1'b1, PH_M));
                sb_q.push_back(mk(1'b1, 1'b1, {2'b01, sw, 1'b0, sw, 3'b000}, 1'b1, PH_M));
            end
            if (kind == K_ALU || kind == K_LW || kind == K_JAL)
                sb_q.push_back(mk(1'b1, 1'b1, 8'b0001_1000, 1'b1, PH_W));
        end

        idx = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            instr_valid = s.iv;
            mem_ready   = s.mr;
            instr       = (s.ph == PH_F) ? w : JUNK;
            #1;
            tag = $sformatf("%s %s[%0d]", name, ph_name(s.ph), idx);
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " reset pulses"},
                      {56'h0, instr_req, mem_req, mem_we, reg_we, pc_we, beq, bne, illegal}, 64'h0);
                check({tag, " reset ctl/ir"}, {alu_ctrl, pc_next, reg_dst, reg_in, alu_src, addr}, 64'h0);
                check({tag, " reset retired"}, {48'h0, retired}, 64'h0);
                sb_q.delete();
                exp_ret = 0;
                @(negedge clk);
                rst_n = 1'b1;
                instr_valid = 1'b0;
                mem_ready = 1'b0;
                @(negedge clk);
                $display("txn %-10s aborted by reset in step %0d", name, idx);
                return;
            end
            check({tag, " pulses"},
                  {56'h0, instr_req, mem_req, mem_we, reg_we, pc_we, beq, bne, illegal},
                  {56'h0, s.vec});
            if (s.chk) begin
                check({tag, " ctl"}, {55'h0, pc_next, alu_src, alu_ctrl, reg_dst, reg_in}, {55'h0, ctl});
                check({tag, " ir"}, {7'h0, rs, rt, rd, imm, addr},
                      {7'h0, w[25:21], w[20:16], w[15:11], w[15:0], w[25:0]});
            end
            idx++;
            @(negedge clk);
        end
        if (kind != K_ILL) exp_ret++;
        #1;
        check({name, " retired"}, {48'h0, retired}, {48'h0, 16'(exp_ret)});
        check({name, " retired_w"}, {60'h0, retired_w}, {60'h0, 4'(exp_ret)});
        $display("txn %-10s %08h cycles=%0d retired=%0d", name, w, idx, retired);
    endtask

    initial begin
        #2;
        check("reset pulses",
              {56'h0, instr_req, mem_req, mem_we, reg_we, pc_we, beq, bne, illegal}, 64'h0);
        check("reset ctl/ir", {alu_ctrl, pc_next, reg_dst, reg_in, alu_src, addr}, 64'h0);
        check("reset retired", {48'h0, retired}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("ADD",    32'h0022_1820, 0, 0, -1);
        run("LW",     32'h8C22_0008, 2, 3, -1);
        run("SW",     32'hAC22_0004, 0, 0, -1);
        run("BNE",    32'h1422_FFFF, 0, 0, -1);
        run("BEQ",    32'h1022_0003, 1, 0, -1);
        run("JAL",    32'h0C00_0100, 0, 0, -1);
        run("ILL_OP", 32'hFC00_0000, 0, 0, -1);
        run("ILL_FN", 32'h0022_1821, 0, 0, -1);
        run("SUB",    32'h0022_1822, 0, 0, -1);
        run("SLT",    32'h0022_182A, 0, 0, -1);
        run("JR",     32'h03E0_0008, 0, 0, -1);
        run("J",      32'h0800_0010, 0, 0, -1);
        run("ADDI",   32'h2022_0005, 0, 0, -1);
        run("XORI",   32'h3822_FFFF, 0, 1, -1);
        // Reset lands in the first MEM cycle of a stalled SW.
        run("SW_RST", 32'hAC22_0004, 0, 2, 3);
        for (int i = 0; i < 15; i++) run("J_FILL", 32'h0800_0010, 0, 0, -1);
        run("ADD_WRAP", 32'h0022_1820, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
